s32x_dreq_fifo: RTL
===================

# s32x_dreq_fifo

Responder end of the SH-2 DMAC external-request handshake. It sits between the MD-side (68000) write port and an SH-2 bus slave address. It buffers 16-bit words in an 8-entry FIFO and drives active-low DREQ to the DMAC while data is pending. Each DMAC read, qualified by DACK, pops one word, and the transfer ends after a programmed word count.

## Interface
Parameters:
- DEPTH_LOG2, 3, FIFO depth is 2^DEPTH_LOG2 16-bit words (8).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE  in  1  clock enable; all state changes only on CLK edges with CE=1
- CFG_WE  in  1  control write strobe
- CFG_EN  in  1  value written with CFG_WE: 1 = start transfer, 0 = abort
- CFG_LEN  in  16  transfer length in words, latched on CFG_WE with CFG_EN=1
- MD_WE  in  1  push strobe, one word per CE cycle
- MD_DI  in  16  push data
- MD_FULL  out  1  FIFO full (count == 8)
- SH_RD  in  1  SH-2 bus read strobe to the FIFO data address; may be held multiple cycles
- DACK  in  1  DMAC acknowledge, active-high, qualifies SH_RD
- SH_DO  out  16  read data, registered
- SH_ACK  out  1  one-CE-cycle pulse: SH_DO valid
- DREQ_N  out  1  DMA request to DMAC, active-low, level mode
- ACTIVE  out  1  transfer in progress
- ERR  out  1  sticky underrun flag

## Operation
- State: mem[8]x16, WP/RP 3-bit wrapping pointers, COUNT 4-bit (0..8), IN_LEFT 16-bit, OUT_LEFT 16-bit, ACTIVE, ERR, RD_OLD.
- Start: CFG_WE & CFG_EN:
  - IN_LEFT = OUT_LEFT = CFG_LEN.
  - ACTIVE = (CFG_LEN != 0).
  - WP, RP and COUNT cleared; ERR cleared.
- Abort: CFG_WE & !CFG_EN clears ACTIVE, WP, RP, COUNT and ERR. IN_LEFT and OUT_LEFT are zeroed.
- Push:
  - Accepted when MD_WE & ACTIVE & COUNT != 8 & IN_LEFT != 0. The word goes to mem[WP], then WP+1 and IN_LEFT-1.
  - Otherwise the word is silently dropped, and no state changes.
- Pop event: SH_RD & DACK & !RD_OLD (rising edge). RD_OLD <= SH_RD & DACK every CE cycle, so a held strobe pops exactly once.
  - COUNT != 0: SH_DO <= mem[RP], RP+1, OUT_LEFT-1. ACTIVE clears when OUT_LEFT goes 1->0.
  - COUNT == 0 (underrun): SH_DO holds its previous value, ERR <= 1, and pointers and counters are unchanged.
  - SH_ACK pulses in both cases, so the bus never hangs.
- SH_RD without DACK: no pop, no SH_ACK. Decoding that access as a register read is outside this block.
- COUNT_next = COUNT + push_ok - pop_ok. Push while full with a simultaneous pop is rejected; full gating uses the current COUNT. A push and a pop on empty in the same cycle: the push is accepted, the pop is an underrun.
- DREQ_N <= ~(ACTIVE_next & COUNT_next != 0), registered, so DREQ_N deasserts on the same edge that consumes the last buffered word.
- CFG_WE has priority over a push or pop in the same cycle; both are ignored.

## Timing
- Reset values: DREQ_N=1, SH_DO=0, SH_ACK=0, MD_FULL=0, ACTIVE=0, ERR=0; internally COUNT=0, WP=RP=0, IN_LEFT=OUT_LEFT=0, RD_OLD=0.
- Push to DREQ_N low: 1 CE cycle (registered on the push edge).
- Pop edge to SH_DO/SH_ACK: SH_DO and SH_ACK are registered on the pop edge and visible the next cycle. SH_ACK drops after 1 CE cycle.
- MD_FULL is combinational from COUNT and updates the cycle after the push or pop.
- ACTIVE falls on the edge of the final pop; DREQ_N is high the same cycle.
- RST_N asserted mid-transfer: all state returns to reset values immediately (asynchronous). No partial word is retained.
- CE=0: all registers hold, including SH_ACK.

## Test plan
- Basic stream:
  - Stimulus: CFG_LEN=3, push 0x1111/0x2222/0x3333, three DACK reads.
  - Response: DREQ_N low 1 cycle after the first push. SH_DO returns 0x1111/0x2222/0x3333, each with a one-cycle SH_ACK. DREQ_N high and ACTIVE=0 on the edge of the third pop.
- Full/wrap:
  - Stimulus: CFG_LEN=20. Push 9 words 0x0000..0x0008. Pop 8, push 4 more, pop 4.
  - Response: MD_FULL=1 after the 8th push and the 9th word is dropped. Pops return 0..7 then 0x0009..0x000C, proving the pointer wrap. COUNT returns to 0.
- Underrun:
  - Stimulus: start with LEN=2, no push, one DACK read.
  - Response: SH_ACK pulses, SH_DO=0, ERR=1, DREQ_N stays high.
  - Then push 0xABCD and read: SH_DO=0xABCD and ERR stays 1.
- Held strobe / no DACK:
  - Stimulus: SH_RD held 5 cycles with DACK=1; then SH_RD with DACK=0.
  - Response: a single pop and SH_ACK for the held strobe; no pop and no SH_ACK without DACK.
- Length limit and abort:
  - Stimulus: CFG_LEN=2, push 3 words.
  - Response: the third word is dropped (IN_LEFT=0).
  - Then CFG_WE with CFG_EN=0 mid-transfer: ACTIVE=0, DREQ_N=1, MD_FULL=0, and later reads underrun.
- Simultaneous and reset:
  - Stimulus: push and pop in the same cycle at COUNT=4; then assert RST_N low mid-transfer.
  - Response: COUNT stays 4 through the simultaneous push/pop. On reset, all outputs return to reset values without waiting for a CLK edge.

Source files
------------

// File: rtl/s32x_dreq_fifo.sv
// SH-2 DMAC external-request responder: 16-bit word FIFO between the MD write port
// and the SH-2 data address, with level-mode DREQ_N and programmed transfer length.
module s32x_dreq_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic        CFG_WE,
    input  logic        CFG_EN,
    input  logic [15:0] CFG_LEN,
    input  logic        MD_WE,
    input  logic [15:0] MD_DI,
    output logic        MD_FULL,
    input  logic        SH_RD,
    input  logic        DACK,
    output logic [15:0] SH_DO,
    output logic        SH_ACK,
    output logic        DREQ_N,
    output logic        ACTIVE,
    output logic        ERR
);

    logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic [DEPTH_LOG2-1:0] wp_reg, wp_next;
    logic [DEPTH_LOG2-1:0] rp_reg, rp_next;
    logic [DEPTH_LOG2:0]   count_reg, count_next;
    logic [15:0]           in_left_reg, in_left_next;
    logic [15:0]           out_left_reg, out_left_next;
    logic                  active_reg, active_next;
    logic                  err_reg, err_next;
    logic                  dreq_n_next;
    logic                  rd_old_reg;
    logic                  ack_reg;
    logic                  dreq_n_reg;
    logic [15:0]           do_reg;

    logic rd_now;
    logic pop_ev;
    logic pop_ok;
    logic push_ok;

    // COUNT never exceeds the depth, so its top bit alone means full.
    assign MD_FULL = count_reg[DEPTH_LOG2];
    assign SH_DO   = do_reg;
    assign SH_ACK  = ack_reg;
    assign DREQ_N  = dreq_n_reg;
    assign ACTIVE  = active_reg;
    assign ERR     = err_reg;

    always_comb begin
        rd_now  = SH_RD & DACK;
        // A control write swallows any push or pop in the same cycle.
        pop_ev  = rd_now & ~rd_old_reg & ~CFG_WE;
        push_ok = MD_WE & active_reg & ~MD_FULL & (in_left_reg != 16'd0) & ~CFG_WE;
        pop_ok  = pop_ev & (count_reg != '0);

        wp_next       = wp_reg;
        rp_next       = rp_reg;
        count_next    = count_reg;
        in_left_next  = in_left_reg;
        out_left_next = out_left_reg;
        active_next   = active_reg;
        err_next      = err_reg;

        if (CFG_WE) begin
            wp_next    = '0;
            rp_next    = '0;
            count_next = '0;
            err_next   = 1'b0;
            if (CFG_EN) begin
                in_left_next  = CFG_LEN;
                out_left_next = CFG_LEN;
                active_next   = (CFG_LEN != 16'd0);
            end else begin
                in_left_next  = '0;
                out_left_next = '0;
                active_next   = 1'b0;
            end
        end else begin
            if (push_ok) begin
                wp_next      = wp_reg + DEPTH_LOG2'(1);
                in_left_next = in_left_reg - 16'd1;
            end
            if (pop_ok) begin
                rp_next = rp_reg + DEPTH_LOG2'(1);
                if (out_left_reg != 16'd0) begin
                    out_left_next = out_left_reg - 16'd1;
                end
                if (out_left_reg == 16'd1) begin
                    active_next = 1'b0;
                end
            end
            if (pop_ev && !pop_ok) begin
                err_next = 1'b1;
            end
            count_next = count_reg + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
        end

        dreq_n_next = ~(active_next & (count_next != '0));
    end

    // Storage is left unreset so it maps onto block RAM; COUNT clearing discards contents.
    always_ff @(posedge CLK) begin
        if (CE && push_ok) begin
            mem[wp_reg] <= MD_DI;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            in_left_reg  <= '0;
            out_left_reg <= '0;
            active_reg   <= 1'b0;
            err_reg      <= 1'b0;
            rd_old_reg   <= 1'b0;
            ack_reg      <= 1'b0;
            dreq_n_reg   <= 1'b1;
            do_reg       <= '0;
        end else if (CE) begin
            wp_reg       <= wp_next;
            rp_reg       <= rp_next;
            count_reg    <= count_next;
            in_left_reg  <= in_left_next;
            out_left_reg <= out_left_next;
            active_reg   <= active_next;
            err_reg      <= err_next;
            rd_old_reg   <= rd_now;
            ack_reg      <= pop_ev;
            dreq_n_reg   <= dreq_n_next;
            if (pop_ok) begin
                do_reg <= mem[rp_reg];
            end
        end
    end

endmodule
